pc_stack_unit: RTL and testbench
================================

# pc_stack_unit

Parametrised program-counter unit for the nanoprocessor family. It extends the plain load/increment PC register with configurable address width, PC-relative branching and a hardware return-address stack for call/return. It sits between the control FSM, which issues one PC command per cycle, and the instruction-memory address bus.

## Interface
- `ADDR_W`, default 8: PC and data_in width in bits; legal range 4..16.
- `STACK_DEPTH`, default 4: number of return-address entries; legal range 1..16.
- `RESET_VEC`, default 0: PC value after reset; must fit in `ADDR_W` bits.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `inc_pc`, in, 1: PC ← PC + 1.
- `load_pc`, in, 1: PC ← data_in (absolute jump).
- `rel_pc`, in, 1: PC ← PC + data_in, with data_in treated as signed two's complement.
- `call`, in, 1: push PC + 1, then PC ← data_in.
- `ret`, in, 1: PC ← top of stack, then pop.
- `clr_err`, in, 1: clears `stack_err`.
- `data_in`, in, `ADDR_W`: jump target or signed offset.
- `pc`, out, `ADDR_W`: current PC, registered.
- `sp`, out, $clog2(STACK_DEPTH+1): number of valid stack entries, registered.
- `stack_empty`, out, 1: high when `sp` == 0.
- `stack_full`, out, 1: high when `sp` == `STACK_DEPTH`.
- `stack_err`, out, 1: sticky flag for overflow or underflow.

## Operation
- **Reset** (asynchronous, `reset_n` = 0):
  - `pc` = `RESET_VEC`, `sp` = 0, `stack_err` = 0.
  - `stack_empty` = 1, `stack_full` = 0.
  - Stack contents are don't-care.
- **Command priority:** exactly one command executes per cycle, in the order `ret` > `call` > `load_pc` > `rel_pc` > `inc_pc`. Lower-priority commands asserted in the same cycle are ignored and raise no error. With no command asserted, `pc` holds.
- **Arithmetic:** all PC arithmetic is modulo 2^`ADDR_W`, with no carry or flag.
  - Increment wraps from 2^`ADDR_W`−1 to 0.
  - `rel_pc`: e.g. `ADDR_W`=8, PC=0x10, data_in=0xFE → PC=0x0E; PC=0xFF, data_in=0x02 → PC=0x01.
- **call:**
  - If not full: stack[sp] ← (PC+1) mod 2^`ADDR_W`, sp ← sp+1, PC ← data_in.
  - If full (overflow): PC ← PC+1 (the call is skipped), stack and sp unchanged, `stack_err` ← 1.
- **ret:**
  - If not empty: PC ← stack[sp−1], sp ← sp−1.
  - If empty (underflow): PC ← PC+1, sp unchanged, `stack_err` ← 1.
- **stack_err:** sticky; it is cleared only by reset or by `clr_err`.
  - If `clr_err` and a new error occur in the same cycle, the error wins and `stack_err` = 1.
- **Flags:** `stack_empty` and `stack_full` are decoded from the registered `sp`, so they are consistent with `sp` in every cycle.
- **Stack organisation:** LIFO register array; no memory macro is required.
- **Reset mid-operation:** asserting `reset_n` low during any command discards it immediately. The stack is logically emptied (sp=0).

## Timing
- **Update latency:** 1 cycle. A command sampled at edge N is visible on `pc`/`sp`/flags after edge N; there is no combinational path from inputs to outputs.
- **Back-to-back commands:** supported every cycle.
  - `call` then `ret` on consecutive cycles returns to the caller's PC+1.
  - `ret` directly after `call` uses the entry pushed in the previous cycle.
- **Reset release:** `reset_n` deassertion is synchronised externally. The first command is accepted on the first rising edge with `reset_n` = 1.
- **Error flag timing:** `stack_err` rises on the same edge as the offending command; `clr_err` takes effect on the next edge.

## Test plan
- **Reset and increment:** `RESET_VEC`=0x00, `ADDR_W`=8; release reset, then `inc_pc` for 257 cycles → `pc` steps 0x01…0xFF, 0x00, 0x01; `sp`=0 and `stack_empty`=1 throughout.
- **Relative branch:** load 0x10 then `rel_pc` with 0xFE → `pc`=0x0E; load 0xFF then `rel_pc` with 0x02 → `pc`=0x01; `rel_pc` with 0x80 from 0x00 → `pc`=0x80.
- **Nested calls:** `STACK_DEPTH`=4.
  - From pc=0x05: call 0x20, 0x30, 0x40, 0x50 → `sp`=4 and `stack_full`=1.
  - 4× `ret` → `pc` = 0x41, 0x31, 0x21, 0x06; `stack_empty`=1 and `stack_err`=0.
- **Overflow and underflow:**
  - With the stack full at pc=0x50: `call` 0x60 → `pc`=0x51, `sp`=4, `stack_err`=1.
  - `clr_err` → `stack_err`=0.
  - Pop all entries, then `ret` → `pc`=previous+1, `sp`=0, `stack_err`=1.
- **Priority:**
  - `ret`+`call`+`inc_pc` asserted together with `sp`=1 and top=0x21 → `pc`=0x21, `sp`=0.
  - `load_pc`+`inc_pc` with data_in=0x33 → `pc`=0x33.
  - `clr_err` in the same cycle as an underflow → `stack_err`=1.
- **Mid-operation reset and parameter sweep:**
  - Assert `reset_n` between edges with `sp`=3 → `pc`=`RESET_VEC` and `sp`=0 immediately, without waiting for a clock edge.
  - Repeat the nested-call test for `ADDR_W`=12, `STACK_DEPTH`=1, `RESET_VEC`=0xFF0.

Source files
------------

// File: rtl/pc_stack_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_stack_unit_if : command/status bundle between control FSM and  |
// | the PC unit.                                       Rev 1.0        |
// +------------------------------------------------------------------+
interface pc_stack_unit_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic              inc_pc;
  logic              load_pc;
  logic              rel_pc;
  logic              call;
  logic              ret;
  logic              clr_err;
  logic [ADDR_W-1:0] data_in;
  logic [ADDR_W-1:0] pc;
  logic [SP_W-1:0]   sp;
  logic              stack_empty;
  logic              stack_full;
  logic              stack_err;

  modport master (
    output inc_pc, load_pc, rel_pc, call, ret, clr_err, data_in,
    input  pc, sp, stack_empty, stack_full, stack_err
  );

  modport slave (
    input  inc_pc, load_pc, rel_pc, call, ret, clr_err, data_in,
    output pc, sp, stack_empty, stack_full, stack_err
  );
endinterface
`default_nettype wire

// File: rtl/pc_stack_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_stack_unit : program counter with relative branch and a LIFO   |
// | return-address stack.                              Rev 1.0        |
// +------------------------------------------------------------------+
module pc_stack_unit #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VEC   = 0
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  pc_stack_unit_if.slave   cmd_if
);
  localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] pc_inc;
  logic              empty, full, push, pop;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign empty  = (sp_q == '0);
  assign full   = (sp_q == SP_FULL);

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q & ~cmd_if.clr_err;
    push  = 1'b0;
    pop   = 1'b0;
    if (cmd_if.ret) begin
      if (empty) begin
        pc_d  = pc_inc;
        err_d = 1'b1;
      end else begin
        pc_d = stack_q[0];
        sp_d = sp_q - SP_W'(1);
        pop  = 1'b1;
      end
    end else if (cmd_if.call) begin
      // A call that cannot push is skipped, so execution falls through.
      if (full) begin
        pc_d  = pc_inc;
        err_d = 1'b1;
      end else begin
        pc_d = cmd_if.data_in;
        sp_d = sp_q + SP_W'(1);
        push = 1'b1;
      end
    end else if (cmd_if.load_pc) begin
      pc_d = cmd_if.data_in;
    end else if (cmd_if.rel_pc) begin
      pc_d = pc_q + cmd_if.data_in;
    end else if (cmd_if.inc_pc) begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= ADDR_W'(RESET_VEC);
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Shift-register LIFO: the top of stack always lives in entry 0.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[0] <= pc_inc;
      for (int i = 1; i < STACK_DEPTH; i++) stack_q[i] <= stack_q[i-1];
    end else if (pop) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) stack_q[i] <= stack_q[i+1];
    end
  end

  assign cmd_if.pc          = pc_q;
  assign cmd_if.sp          = sp_q;
  assign cmd_if.stack_empty = empty;
  assign cmd_if.stack_full  = full;
  assign cmd_if.stack_err   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pc_stack_unit : directed vectors for pc_stack_unit, default    |
// | and 12-bit/depth-1 configurations.                 Rev 1.0        |
// +------------------------------------------------------------------+
module tb_pc_stack_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  // Command encoding {ret, call, load, rel, inc, clr}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_CLR  = 6'b000001;
  localparam logic [5:0] C_INC  = 6'b000010;
  localparam logic [5:0] C_REL  = 6'b000100;
  localparam logic [5:0] C_LOAD = 6'b001000;
  localparam logic [5:0] C_CALL = 6'b010000;
  localparam logic [5:0] C_RET  = 6'b100000;

  pc_stack_unit_if #(.ADDR_W(8),  .STACK_DEPTH(4)) b8 ();
  pc_stack_unit_if #(.ADDR_W(12), .STACK_DEPTH(1)) b12 ();

  pc_stack_unit #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_VEC(0)) dut8 (
    .clk(clk), .reset_n(reset_n), .cmd_if(b8.slave));
  pc_stack_unit #(.ADDR_W(12), .STACK_DEPTH(1), .RESET_VEC(12'hFF0)) dut12 (
    .clk(clk), .reset_n(reset_n), .cmd_if(b12.slave));

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmd8(input logic [5:0] c, input logic [7:0] d);
    {b8.ret, b8.call, b8.load_pc, b8.rel_pc, b8.inc_pc, b8.clr_err} = c;
    b8.data_in = d;
    @(posedge clk);
    #1;
    {b8.ret, b8.call, b8.load_pc, b8.rel_pc, b8.inc_pc, b8.clr_err} = C_NONE;
  endtask

  task automatic cmd12(input logic [5:0] c, input logic [11:0] d);
    {b12.ret, b12.call, b12.load_pc, b12.rel_pc, b12.inc_pc, b12.clr_err} = c;
    b12.data_in = d;
    @(posedge clk);
    #1;
    {b12.ret, b12.call, b12.load_pc, b12.rel_pc, b12.inc_pc, b12.clr_err} = C_NONE;
  endtask

  initial begin
    {b8.ret, b8.call, b8.load_pc, b8.rel_pc, b8.inc_pc, b8.clr_err} = C_NONE;
    {b12.ret, b12.call, b12.load_pc, b12.rel_pc, b12.inc_pc, b12.clr_err} = C_NONE;
    b8.data_in  = '0;
    b12.data_in = '0;
    #2 reset_n = 1'b0;
    #1;
    check_vec("rst_pc",    b8.pc, 32'h00);
    check_vec("rst_sp",    b8.sp, 32'd0);
    check_vec("rst_empty", b8.stack_empty, 32'd1);
    check_vec("rst_full",  b8.stack_full, 32'd0);
    check_vec("rst_err",   b8.stack_err, 32'd0);
    check_vec("rst_pc12",  b12.pc, 32'hFF0);
    #9 reset_n = 1'b1;   // released between edges

    // Increment across the wrap point
    for (int i = 1; i <= 257; i++) begin
      cmd8(C_INC, 8'h00);
      check_vec("inc_pc", b8.pc, i % 256);
      check_vec("inc_empty", b8.stack_empty, 32'd1);
    end
    check_vec("inc_sp", b8.sp, 32'd0);

    // Relative branches
    cmd8(C_LOAD, 8'h10); cmd8(C_REL, 8'hFE); check_vec("rel_back", b8.pc, 32'h0E);
    cmd8(C_LOAD, 8'hFF); cmd8(C_REL, 8'h02); check_vec("rel_wrap", b8.pc, 32'h01);
    cmd8(C_LOAD, 8'h00); cmd8(C_REL, 8'h80); check_vec("rel_min",  b8.pc, 32'h80);

    // Nested calls to full, then overflow
    cmd8(C_LOAD, 8'h05);
    cmd8(C_CALL, 8'h20); check_vec("call1_pc", b8.pc, 32'h20); check_vec("call1_sp", b8.sp, 32'd1);
    cmd8(C_CALL, 8'h30); cmd8(C_CALL, 8'h40);
    cmd8(C_CALL, 8'h50); check_vec("call4_pc", b8.pc, 32'h50);
    check_vec("call4_sp", b8.sp, 32'd4);
    check_vec("call4_full", b8.stack_full, 32'd1);
    check_vec("call4_err", b8.stack_err, 32'd0);
    cmd8(C_CALL, 8'h60);
    check_vec("ovf_pc", b8.pc, 32'h51);
    check_vec("ovf_sp", b8.sp, 32'd4);
    check_vec("ovf_err", b8.stack_err, 32'd1);
    cmd8(C_CLR, 8'h00);
    check_vec("clr_err", b8.stack_err, 32'd0);
    check_vec("clr_pc_hold", b8.pc, 32'h51);

    // Unwind
    cmd8(C_RET, 8'h00); check_vec("ret1_pc", b8.pc, 32'h41); check_vec("ret1_full", b8.stack_full, 32'd0);
    cmd8(C_RET, 8'h00); check_vec("ret2_pc", b8.pc, 32'h31);
    cmd8(C_RET, 8'h00); check_vec("ret3_pc", b8.pc, 32'h21);
    cmd8(C_RET, 8'h00); check_vec("ret4_pc", b8.pc, 32'h06);
    check_vec("ret4_empty", b8.stack_empty, 32'd1);
    check_vec("ret4_err", b8.stack_err, 32'd0);
    cmd8(C_RET, 8'h00);
    check_vec("unf_pc", b8.pc, 32'h07);
    check_vec("unf_sp", b8.sp, 32'd0);
    check_vec("unf_err", b8.stack_err, 32'd1);
    cmd8(C_CLR, 8'h00);
    check_vec("clr2_err", b8.stack_err, 32'd0);

    // Priority
    cmd8(C_LOAD, 8'h20); cmd8(C_CALL, 8'h40);
    cmd8(C_RET | C_CALL | C_INC, 8'h99);
    check_vec("pri_ret_pc", b8.pc, 32'h21);
    check_vec("pri_ret_sp", b8.sp, 32'd0);
    check_vec("pri_ret_err", b8.stack_err, 32'd0);
    cmd8(C_LOAD | C_INC, 8'h33); check_vec("pri_load", b8.pc, 32'h33);
    cmd8(C_RET | C_CLR, 8'h00);
    check_vec("pri_clr_unf_pc", b8.pc, 32'h34);
    check_vec("pri_clr_unf_err", b8.stack_err, 32'd1);
    cmd8(C_CLR, 8'h00);
    cmd8(C_REL | C_INC, 8'h05); check_vec("pri_rel", b8.pc, 32'h39);
    cmd8(C_NONE, 8'hAA); check_vec("idle_hold", b8.pc, 32'h39);

    // Back-to-back call/ret
    cmd8(C_CALL, 8'h70); check_vec("b2b_call", b8.pc, 32'h70);
    cmd8(C_RET, 8'h00);  check_vec("b2b_ret", b8.pc, 32'h3A);
    check_vec("b2b_sp", b8.sp, 32'd0);

    // Asynchronous reset with sp=3
    cmd8(C_LOAD, 8'h10);
    cmd8(C_CALL, 8'h20); cmd8(C_CALL, 8'h30); cmd8(C_CALL, 8'h40);
    check_vec("pre_rst_sp", b8.sp, 32'd3);
    #3 reset_n = 1'b0;
    #1;
    check_vec("mid_rst_pc", b8.pc, 32'h00);
    check_vec("mid_rst_sp", b8.sp, 32'd0);
    check_vec("mid_rst_empty", b8.stack_empty, 32'd1);
    check_vec("mid_rst_pc12", b12.pc, 32'hFF0);
    #2 reset_n = 1'b1;

    // 12-bit, depth-1 configuration
    cmd12(C_INC, 12'h000); check_vec("w12_inc", b12.pc, 32'hFF1);
    cmd12(C_LOAD, 12'hFFF); cmd12(C_INC, 12'h000); check_vec("w12_wrap", b12.pc, 32'h000);
    cmd12(C_LOAD, 12'h005);
    cmd12(C_CALL, 12'h200);
    check_vec("w12_call_pc", b12.pc, 32'h200);
    check_vec("w12_call_full", b12.stack_full, 32'd1);
    check_vec("w12_call_sp", b12.sp, 32'd1);
    cmd12(C_CALL, 12'h300);
    check_vec("w12_ovf_pc", b12.pc, 32'h201);
    check_vec("w12_ovf_err", b12.stack_err, 32'd1);
    cmd12(C_CLR, 12'h000);
    cmd12(C_RET, 12'h000);
    check_vec("w12_ret_pc", b12.pc, 32'h006);
    check_vec("w12_ret_empty", b12.stack_empty, 32'd1);
    check_vec("w12_ret_err", b12.stack_err, 32'd0);
    cmd12(C_RET, 12'h000);
    check_vec("w12_unf_pc", b12.pc, 32'h007);
    check_vec("w12_unf_err", b12.stack_err, 32'd1);
    cmd12(C_REL, 12'hFFE); check_vec("w12_rel", b12.pc, 32'h005);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
